dm_copy_engine: RTL and testbench
=================================

DM_COPY_ENGINE -- requirements
Module: dm_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 10, data-memory word-address width (1024 words).
REQ-002 Parameter DATA_W, default 17, data-memory word width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 Port mode  input  1  0 = copy src->dst, 1 = fill dst with fill_val; sampled with start.
REQ-007 Port src_addr  input  ADDR_W  first source word address; sampled with start.
REQ-008 Port dst_addr  input  ADDR_W  first destination word address; sampled with start.
REQ-009 Port len  input  ADDR_W+1  word count, 0..1024; sampled with start.
REQ-010 Port fill_val  input  DATA_W  fill pattern; sampled with start.
REQ-011 Port busy  output  1  high while memory accesses are pending or in progress.
REQ-012 Port done  output  1  one-cycle completion pulse.
REQ-013 Port dm_addr  output  ADDR_W  memory word address.
REQ-014 Port dm_re  output  1  memory read enable.
REQ-015 Port dm_we  output  1  memory write enable.
REQ-016 Port dm_wrt_data  output  DATA_W  memory write data.
REQ-017 Port dm_rd_data  input  DATA_W  memory read data; valid at the rising edge after the cycle dm_re was high.

Function
REQ-018 The engine SHALL drive dm_addr, dm_re, dm_we, dm_wrt_data, busy and done directly from flops.
REQ-019 The engine SHALL never assert dm_re and dm_we in the same cycle.
REQ-020 States SHALL be IDLE, RD, WR, FILL, DONE.
REQ-021 IDLE + start + len=0 SHALL go to DONE, issuing no memory access.
REQ-022 IDLE + start + len>0 SHALL go to RD for mode=0, or FILL for mode=1, latching all request inputs.
REQ-023 RD (one cycle): dm_re=1, dm_addr=current src; next state WR.
REQ-024 Entering WR, the engine SHALL capture dm_rd_data into the write-data register.
REQ-025 WR (one cycle): dm_we=1, dm_addr=current dst, dm_wrt_data=captured word.
REQ-026 After WR, src, dst and remaining count SHALL advance by 1, 1 and -1.
REQ-027 WR SHALL go to DONE when the remaining count reaches 0, else to RD.
REQ-028 FILL (one cycle per word): dm_we=1, dm_addr=current dst, dm_wrt_data=fill_val latched; dst advances; state repeats until count reaches 0, then goes to DONE.
REQ-029 Address increments SHALL wrap modulo 2^ADDR_W (1023 -> 0).
REQ-030 Copy SHALL proceed strictly in ascending address order; overlapping regions with src<dst replicate data, and this is correct behaviour.
REQ-031 Copy latency: with start high in cycle 0, there is one RD/WR pair per word in cycles 1..2L; done is high in cycle 2L+1.
REQ-032 Fill latency: writes occur in cycles 1..L; done is high in cycle L+1.
REQ-033 DONE SHALL last one cycle with done=1, busy=0 and no access, then return to IDLE.
REQ-034 busy SHALL be 1 exactly in RD, WR and FILL.
REQ-035 start SHALL be ignored outside IDLE, with no effect on the transfer in flight.
REQ-036 dm_re, dm_we and dm_addr SHALL be 0 in IDLE and DONE; dm_wrt_data holds its last value.

Reset
REQ-037 rst_n low SHALL immediately force IDLE, with busy, done, dm_re, dm_we, dm_addr, dm_wrt_data and all counters at 0.
REQ-038 Reset mid-transfer SHALL abort it without a done pulse; words already written stay written.
REQ-039 After rst_n rises, the first accepted start SHALL behave per REQ-021/022.

Verification
REQ-040 Copy: mem[0x010..0x012]=0x1AAAA,0x00001,0x15555; start mode=0 src=0x010 dst=0x200 len=3 -> re/we alternate cycles 1-6, never together; mem[0x200..0x202] match the source; done in cycle 7.
REQ-041 Fill: start mode=1 dst=0x3FE len=4 fill_val=0x0BEEF -> writes 0x3FE,0x3FF,0x000,0x001 in cycles 1-4; done in cycle 5.
REQ-042 Zero length: start len=0 -> no re/we; busy stays 0; done in cycle 1.
REQ-043 Ignored start: second start during busy with different dst -> original transfer unchanged; exactly one done pulse.
REQ-044 Reset abort: copy len=8 with rst_n low in cycle 5 -> all outputs 0 within that cycle; no done; only the first 2 destination words updated.
REQ-045 Overlap: mem[0x100]=0x00007; copy src=0x100 dst=0x101 len=3 -> mem[0x101..0x103] all 0x00007.

Source files
------------

// File: rtl/dm_copy_engine.sv
// Word-at-a-time data-memory copy/fill engine: one read/write pair per copied word,
// one write per filled word, with every memory-facing output driven from a flop.
module dm_copy_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_re,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_wrt_data,
    input  logic [DATA_W-1:0] dm_rd_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   cnt;

    // cnt holds the words still to be finished, including the one in progress;
    // the fill pattern lives in dm_wrt_data, which is otherwise untouched during FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            src         <= '0;
            dst         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dm_addr     <= '0;
            dm_re       <= 1'b0;
            dm_we       <= 1'b0;
            dm_wrt_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            src  <= src_addr;
                            dst  <= dst_addr;
                            cnt  <= len;
                            busy <= 1'b1;
                            if (mode) begin
                                state       <= S_FILL;
                                dm_we       <= 1'b1;
                                dm_addr     <= dst_addr;
                                dm_wrt_data <= fill_val;
                            end else begin
                                state   <= S_RD;
                                dm_re   <= 1'b1;
                                dm_addr <= src_addr;
                            end
                        end
                    end
                end
                S_RD: begin
                    state       <= S_WR;
                    dm_re       <= 1'b0;
                    dm_we       <= 1'b1;
                    dm_addr     <= dst;
                    dm_wrt_data <= dm_rd_data;
                end
                S_WR: begin
                    src   <= src + ADDR_ONE;
                    dst   <= dst + ADDR_ONE;
                    cnt   <= cnt - CNT_ONE;
                    dm_we <= 1'b0;
                    if (cnt == CNT_ONE) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dm_addr <= '0;
                    end else begin
                        state   <= S_RD;
                        dm_re   <= 1'b1;
                        dm_addr <= src + ADDR_ONE;
                    end
                end
                S_FILL: begin
                    dst <= dst + ADDR_ONE;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dm_we   <= 1'b0;
                        dm_addr <= '0;
                    end else begin
                        dm_addr <= dst + ADDR_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    dm_re   <= 1'b0;
                    dm_we   <= 1'b0;
                    dm_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Directed bench for dm_copy_engine: per-cycle output traces and memory contents
// compared against hand-computed tables, one task per scenario.
module tb_dm_copy_engine;

    localparam int AW = 10;
    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_val = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] dm_addr;
    logic          dm_re;
    logic          dm_we;
    logic [DW-1:0] dm_wrt_data;
    logic [DW-1:0] dm_rd_data;

    logic [DW-1:0] mem [0:1023];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_data = '0;

    int total = 0;
    int bad = 0;
    int both_cnt = 0;
    int done_cnt = 0;

    // {busy, done, dm_re, dm_we, dm_addr}
    wire [13:0] obs = {busy, done, dm_re, dm_we, dm_addr};

    always #5 clk = ~clk;

    dm_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
        .dm_wrt_data(dm_wrt_data), .dm_rd_data(dm_rd_data)
    );

    // Read data is available during the dm_re cycle, so the engine captures it on the next edge.
    assign dm_rd_data = dm_re ? mem[dm_addr] : '0;

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wrt_data;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    always @(negedge clk) begin
        if (dm_re && dm_we) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Start is high in cycle 0; returns just after the edge that begins cycle 1.
    task automatic kick(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW:0] l, input logic [DW-1:0] f);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (obs !== 14'h0 || dm_wrt_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs obs=%h wd=%h want obs=0 wd=0", obs, dm_wrt_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL idle_no_start obs=%h want 0", obs);
        end
        $display("test_reset done");
    endtask

    task automatic test_copy();
        logic [13:0]   want [7];
        logic [DW-1:0] src_vals [3];
        int b0;
        src_vals[0] = 17'h1AAAA; src_vals[1] = 17'h00001; src_vals[2] = 17'h15555;
        want[0] = {4'b1010, 10'h010}; want[1] = {4'b1001, 10'h200};
        want[2] = {4'b1010, 10'h011}; want[3] = {4'b1001, 10'h201};
        want[4] = {4'b1010, 10'h012}; want[5] = {4'b1001, 10'h202};
        want[6] = {4'b0100, 10'h000};
        for (int i = 0; i < 3; i++) poke(AW'(12'h010 + i), src_vals[i]);
        for (int i = 0; i < 3; i++) poke(AW'(12'h200 + i), '0);
        b0 = both_cnt;
        kick(1'b0, 10'h010, 10'h200, 11'd3, '0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++;
            if (obs !== want[k]) begin
                bad++;
                $display("FAIL copy_cycle%0d obs=%h want=%h", k + 1, obs, want[k]);
            end
            if (want[k][10]) begin
                total++;
                if (dm_wrt_data !== src_vals[k / 2]) begin
                    bad++;
                    $display("FAIL copy_wdata_cycle%0d got=%h want=%h", k + 1, dm_wrt_data, src_vals[k / 2]);
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem[AW'(12'h200 + i)] !== src_vals[i]) begin
                bad++;
                $display("FAIL copy_mem%0d got=%h want=%h", i, mem[AW'(12'h200 + i)], src_vals[i]);
            end
        end
        total++;
        if (both_cnt !== b0) begin
            bad++;
            $display("FAIL copy_re_we_overlap got=%0d want=%0d", both_cnt, b0);
        end
        $display("test_copy done");
    endtask

    task automatic test_fill();
        logic [13:0] want [5];
        want[0] = {4'b1001, 10'h3FE}; want[1] = {4'b1001, 10'h3FF};
        want[2] = {4'b1001, 10'h000}; want[3] = {4'b1001, 10'h001};
        want[4] = {4'b0100, 10'h000};
        poke(10'h3FE, '0); poke(10'h3FF, '0); poke(10'h000, '0); poke(10'h001, '0);
        kick(1'b1, 10'h000, 10'h3FE, 11'd4, 17'h0BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (obs !== want[k] || dm_wrt_data !== 17'h0BEEF) begin
                bad++;
                $display("FAIL fill_cycle%0d obs=%h wd=%h want=%h wd=0beef", k + 1, obs, dm_wrt_data, want[k]);
            end
        end
        @(posedge clk); #1;
        total++;
        if (mem[10'h3FE] !== 17'h0BEEF || mem[10'h3FF] !== 17'h0BEEF ||
            mem[10'h000] !== 17'h0BEEF || mem[10'h001] !== 17'h0BEEF) begin
            bad++;
            $display("FAIL fill_mem got=%h %h %h %h want=0beef x4",
                     mem[10'h3FE], mem[10'h3FF], mem[10'h000], mem[10'h001]);
        end
        $display("test_fill done");
    endtask

    task automatic test_zero_len();
        kick(1'b0, 10'h005, 10'h006, 11'd0, '0);
        @(negedge clk);
        total++;
        if (obs !== {4'b0100, 10'h000}) begin
            bad++;
            $display("FAIL zero_cycle1 obs=%h want=%h", obs, {4'b0100, 10'h000});
        end
        @(negedge clk);
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL zero_cycle2 obs=%h want=0", obs);
        end
        @(posedge clk); #1;
        $display("test_zero_len done");
    endtask

    task automatic test_ignored_start();
        int d0;
        poke(10'h050, '0); poke(10'h051, '0); poke(10'h052, '0); poke(10'h060, '0);
        d0 = done_cnt;
        kick(1'b1, 10'h000, 10'h050, 11'd2, 17'h00123);
        start = 1'b1; mode = 1'b1; dst_addr = 10'h060; len = 11'd5; fill_val = 17'h1FFFF;
        @(negedge clk);
        total++;
        if (obs !== {4'b1001, 10'h050}) begin
            bad++;
            $display("FAIL ign_cycle1 obs=%h want=%h", obs, {4'b1001, 10'h050});
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== {4'b1001, 10'h051} || dm_wrt_data !== 17'h00123) begin
            bad++;
            $display("FAIL ign_cycle2 obs=%h wd=%h want=%h wd=00123", obs, dm_wrt_data, {4'b1001, 10'h051});
        end
        @(negedge clk);
        total++;
        if (obs !== {4'b0100, 10'h000}) begin
            bad++;
            $display("FAIL ign_cycle3 obs=%h want=%h", obs, {4'b0100, 10'h000});
        end
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL ign_done_pulses got=%0d want=1", done_cnt - d0);
        end
        total++;
        if (mem[10'h050] !== 17'h00123 || mem[10'h051] !== 17'h00123 ||
            mem[10'h052] !== '0 || mem[10'h060] !== '0) begin
            bad++;
            $display("FAIL ign_mem got=%h %h %h %h want=00123 00123 0 0",
                     mem[10'h050], mem[10'h051], mem[10'h052], mem[10'h060]);
        end
        $display("test_ignored_start done");
    endtask

    task automatic test_reset_abort();
        int d0;
        for (int i = 0; i < 8; i++) poke(AW'(12'h300 + i), DW'(17'h10000 + i));
        for (int i = 0; i < 3; i++) poke(AW'(12'h380 + i), '0);
        poke(10'h3C0, '0);
        d0 = done_cnt;
        kick(1'b0, 10'h300, 10'h380, 11'd8, '0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 14'h0 || dm_wrt_data !== '0) begin
            bad++;
            $display("FAIL abort_outputs obs=%h wd=%h want obs=0 wd=0", obs, dm_wrt_data);
        end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        total++;
        if (done_cnt !== d0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d want=%0d", done_cnt, d0);
        end
        total++;
        if (mem[10'h380] !== 17'h10000 || mem[10'h381] !== 17'h10001 || mem[10'h382] !== '0) begin
            bad++;
            $display("FAIL abort_mem got=%h %h %h want=10000 10001 0",
                     mem[10'h380], mem[10'h381], mem[10'h382]);
        end
        kick(1'b1, 10'h000, 10'h3C0, 11'd1, 17'h00ABC);
        @(negedge clk);
        total++;
        if (obs !== {4'b1001, 10'h3C0}) begin
            bad++;
            $display("FAIL post_reset_cycle1 obs=%h want=%h", obs, {4'b1001, 10'h3C0});
        end
        @(negedge clk);
        total++;
        if (obs !== {4'b0100, 10'h000} || mem[10'h3C0] !== 17'h00ABC) begin
            bad++;
            $display("FAIL post_reset_cycle2 obs=%h mem=%h want=%h mem=00abc",
                     obs, mem[10'h3C0], {4'b0100, 10'h000});
        end
        @(posedge clk); #1;
        $display("test_reset_abort done");
    endtask

    task automatic test_overlap();
        poke(10'h100, 17'h00007);
        for (int i = 1; i < 4; i++) poke(AW'(12'h100 + i), '0);
        kick(1'b0, 10'h100, 10'h101, 11'd3, '0);
        repeat (7) @(negedge clk);
        total++;
        if (obs !== {4'b0100, 10'h000}) begin
            bad++;
            $display("FAIL overlap_done obs=%h want=%h", obs, {4'b0100, 10'h000});
        end
        @(posedge clk); #1;
        for (int i = 1; i < 4; i++) begin
            total++;
            if (mem[AW'(12'h100 + i)] !== 17'h00007) begin
                bad++;
                $display("FAIL overlap_mem%0d got=%h want=00007", i, mem[AW'(12'h100 + i)]);
            end
        end
        $display("test_overlap done");
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_zero_len();
        test_ignored_start();
        test_reset_abort();
        test_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
